// File: rtl/ad_uart_pkg.sv
// ad_uart_pkg: shared FSM state encoding and default widths for the ADC capture scheduler
package ad_uart_pkg;
    localparam int STATE_W   = 3;
    localparam int DIV_W_DEF = 16;

    typedef enum logic [STATE_W-1:0] {
        IDLE,
        WAIT_TICK,
        CONV,
        DRAIN_RD,
        DRAIN_TX,
        DRAIN_WAIT
    } state_e;
endpackage

// File: rtl/sample_tick_gen.sv
// sample_tick_gen: loadable down-counter that emits a terminal-count pulse every period cycles while enabled
module sample_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] period,
    output logic             tc
);
    logic [DIV_W-1:0] cnt_q, cnt_d, reload;

    // A period of 0 behaves like 1; the counter reloads itself on every terminal count
    always_comb begin
        reload = (period == '0) ? '0 : period - DIV_W'(1);
        tc     = en && !load && (cnt_q == '0);
        cnt_d  = load ? reload : !en ? cnt_q : tc ? reload : cnt_q - DIV_W'(1);
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/ad_capture_sched.sv
// ad_capture_sched: schedules ADC conversions into a FIFO, then drains the FIFO to a UART.
// Optional CONV watchdog and timeout port enabled by defining AD_CAPTURE_TIMEOUT_EN.
module ad_capture_sched
    import ad_uart_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_done,
    input  logic [7:0]       receive_time,
    input  logic [DIV_W-1:0] sample_div,
    output logic             ad_start,
    input  logic             ad_done,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    output logic             fifo_wr_en,
    output logic             fifo_rd_en,
    output logic             tx_start,
    input  logic             tx_done,
    output logic             busy,
    output logic             overflow
`ifdef AD_CAPTURE_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);
    state_e           state_q, state_d;
    logic [7:0]       rt_q, rt_d, cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d, tick_period;
    logic             ovf_q, ovf_d;
    logic             ad_start_q, ad_start_d, wr_q, wr_d, rd_q, rd_d, tx_q, tx_d;
    logic             tick_load, tick_en, tick_tc, last;
`ifdef AD_CAPTURE_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            to_q, to_d;
    assign timeout = to_q;
`endif

    // The divider loads straight from the input on set_done, otherwise from the latched value
    assign tick_period = (state_q == IDLE) ? sample_div : div_q;
    assign last        = ({1'b0, cnt_q} + 9'd1) == {1'b0, rt_q};
    assign ad_start    = ad_start_q;
    assign fifo_wr_en  = wr_q;
    assign fifo_rd_en  = rd_q;
    assign tx_start    = tx_q;
    assign busy        = state_q != IDLE;
    assign overflow    = ovf_q;

    sample_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tick_load),
        .en     (tick_en),
        .period (tick_period),
        .tc     (tick_tc)
    );

    // Next-state and strobe decode; every strobe is registered so each appears one cycle after its decision
    always_comb begin
        state_d    = state_q;
        rt_d       = rt_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        ad_start_d = 1'b0;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        tx_d       = 1'b0;
        tick_load  = 1'b0;
        tick_en    = 1'b0;
`ifdef AD_CAPTURE_TIMEOUT_EN
        to_d       = to_q;
        wd_d       = '0;
`endif
        unique case (state_q)
            IDLE: if (set_done) begin
                rt_d      = receive_time;
                div_d     = sample_div;
                cnt_d     = '0;
                ovf_d     = 1'b0;
                tick_load = 1'b1;
`ifdef AD_CAPTURE_TIMEOUT_EN
                to_d      = 1'b0;
`endif
                state_d   = (receive_time == '0) ? IDLE : WAIT_TICK;
            end
            WAIT_TICK: begin
                tick_en    = 1'b1;
                ad_start_d = tick_tc;
                state_d    = tick_tc ? CONV : WAIT_TICK;
            end
            CONV: begin
                if (ad_done) begin
                    wr_d    = !fifo_full;
                    ovf_d   = ovf_q | fifo_full;
                    cnt_d   = cnt_q + 8'd1;
                    state_d = last ? DRAIN_RD : WAIT_TICK;
                end
`ifdef AD_CAPTURE_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    to_d    = 1'b1;
                    state_d = DRAIN_RD;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
`endif
            end
            // Hold while the final write is still in flight so fifo_empty reflects it
            DRAIN_RD: if (!wr_q) begin
                rd_d    = !fifo_empty;
                state_d = fifo_empty ? IDLE : DRAIN_TX;
            end
            DRAIN_TX: begin
                tx_d    = 1'b1;
                state_d = DRAIN_WAIT;
            end
            DRAIN_WAIT: state_d = tx_done ? DRAIN_RD : DRAIN_WAIT;
            default:    state_d = IDLE;
        endcase
    end

    // State, latched session parameters and registered strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rt_q       <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            ad_start_q <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            tx_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rt_q       <= rt_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            ad_start_q <= ad_start_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            tx_q       <= tx_d;
        end
    end

`ifdef AD_CAPTURE_TIMEOUT_EN
    // CONV watchdog counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end
`endif
endmodule

// File: tb/tb_ad_capture_sched.sv
// tb_ad_capture_sched: table-driven, hand-sequenced and randomized sessions against a transaction-count model
module tb_ad_capture_sched;
    localparam int DIV_W = 16;

    typedef struct {
        int          rt;
        int          div;
        int          d;
        logic [31:0] mask;
        bit          st;
        int          e_start;
        int          e_wr;
        bit          e_ovf;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic set_done_t = 1'b0, stray_set = 1'b0, set_done;
    logic [7:0] receive_time = '0;
    logic [DIV_W-1:0] sample_div = '0;
    logic ad_start, fifo_wr_en, fifo_rd_en, tx_start, busy, overflow;
    logic ad_done = 1'b0, fifo_full = 1'b0, fifo_empty = 1'b1, tx_done = 1'b0;
`ifdef AD_CAPTURE_TIMEOUT_EN
    logic timeout;
`endif

    int checks = 0, errors = 0;
    int cyc = 0, sess = 0, mon_sess = 0, rsp_sess = 0;
    int n_start = 0, n_wr = 0, n_rd = 0, n_tx = 0, busy_hi = 0, proto_err = 0, spacing_err = 0;
    int last_start = -1, occ = 0, div_eff = 1, adc_d = 1, adc_idx = 0;
    bit prev_rd = 1'b0, fifo_flush = 1'b0, adc_mute = 1'b0, stray = 1'b0;
    logic [31:0] full_mask = '0;

    assign set_done = set_done_t | stray_set;
    always #5 clk = ~clk;

    ad_capture_sched #(.DIV_W(DIV_W), .TIMEOUT_CYC(1023)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .set_done     (set_done),
        .receive_time (receive_time),
        .sample_div   (sample_div),
        .ad_start     (ad_start),
        .ad_done      (ad_done),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_rd_en   (fifo_rd_en),
        .tx_start     (tx_start),
        .tx_done      (tx_done),
        .busy         (busy),
        .overflow     (overflow)
`ifdef AD_CAPTURE_TIMEOUT_EN
        ,
        .timeout      (timeout)
`endif
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Bus monitor, protocol rules and the external FIFO occupancy (flags lag writes by one cycle)
    initial forever begin
        @(negedge clk);
        cyc++;
        if (mon_sess != sess) begin
            mon_sess   = sess;
            last_start = -1;
        end
        if (int'(ad_start) + int'(fifo_wr_en) + int'(fifo_rd_en) + int'(tx_start) > 1) proto_err++;
        if (tx_start != prev_rd) proto_err++;
        if (fifo_rd_en && occ == 0) proto_err++;
        prev_rd = fifo_rd_en;
        if (busy) busy_hi++;
        if (ad_start) begin
            if (last_start >= 0 && cyc - last_start < div_eff) spacing_err++;
            last_start = cyc;
            n_start++;
        end
        if (fifo_wr_en) n_wr++;
        if (fifo_rd_en) n_rd++;
        if (tx_start) n_tx++;
        fifo_empty = (occ == 0);
        occ = fifo_flush ? 0 : occ + int'(fifo_wr_en) - int'(fifo_rd_en);
    end

    // ADC model: ad_done adc_d cycles after ad_start, per-sample full flag, optional stray pulses
    initial forever begin
        @(negedge clk);
        if (rsp_sess != sess) begin
            rsp_sess = sess;
            adc_idx  = 0;
        end
        if (ad_start && !adc_mute) begin
            fifo_full = (adc_idx < 32) ? full_mask[adc_idx] : 1'b0;
            adc_idx++;
            for (int k = 1; k <= adc_d; k++) begin
                @(negedge clk);
                stray_set = stray && (k == 1);
            end
            ad_done = 1'b1;
            @(negedge clk);
            ad_done   = 1'b0;
            fifo_full = 1'b0;
            stray_set = 1'b0;
            if (stray) begin
                @(negedge clk);
                ad_done = 1'b1;
                @(negedge clk);
                ad_done = 1'b0;
            end
        end
    end

    // UART model: tx_done two cycles after tx_start
    initial forever begin
        @(negedge clk);
        if (tx_start) begin
            repeat (2) @(negedge clk);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end
    end

    task automatic start_session(input int rt, input int div, input int d, input logic [31:0] mask, input bit st);
        sess++;
        adc_d        = d;
        full_mask    = mask;
        stray        = st;
        div_eff      = (div == 0) ? 1 : div;
        receive_time = 8'(rt);
        sample_div   = DIV_W'(div);
        set_done_t   = 1'b1;
        @(negedge clk);
        set_done_t   = 1'b0;
    endtask

    task automatic run_session(input string tag, input vec_t v);
        int s0, w0, r0, t0, b0, p0, sp0, k;
        s0 = n_start; w0 = n_wr; r0 = n_rd; t0 = n_tx; b0 = busy_hi; p0 = proto_err; sp0 = spacing_err;
        start_session(v.rt, v.div, v.d, v.mask, v.st);
        check($sformatf("%s ovf_clear", tag), overflow, 0);
        k = 0;
        while (busy && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("%s finished", tag), busy, 0);
        repeat (30) @(negedge clk);
        check($sformatf("%s ad_start", tag), n_start - s0, v.e_start);
        check($sformatf("%s wr_en", tag), n_wr - w0, v.e_wr);
        check($sformatf("%s rd_en", tag), n_rd - r0, v.e_wr);
        check($sformatf("%s tx_start", tag), n_tx - t0, v.e_wr);
        check($sformatf("%s overflow", tag), overflow, v.e_ovf);
        check($sformatf("%s protocol", tag), proto_err - p0, 0);
        check($sformatf("%s spacing", tag), spacing_err - sp0, 0);
        if (v.rt == 0) check($sformatf("%s busy_seen", tag), busy_hi - b0, 0);
    endtask

    initial begin
        #800000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t tbl[8];
        vec_t v;
        int k, rd0;
        tbl[0] = '{4,   10,  3, 32'h0,  1'b0, 4,   4,   1'b0};
        tbl[1] = '{0,   10,  3, 32'h0,  1'b0, 0,   0,   1'b0};
        tbl[2] = '{3,   5,   2, 32'h2,  1'b0, 3,   2,   1'b1};
        tbl[3] = '{1,   0,   1, 32'h0,  1'b0, 1,   1,   1'b0};
        tbl[4] = '{3,   10,  3, 32'h0,  1'b1, 3,   3,   1'b0};
        tbl[5] = '{5,   1,   1, 32'h1F, 1'b0, 5,   0,   1'b1};
        tbl[6] = '{2,   300, 4, 32'h0,  1'b0, 2,   2,   1'b0};
        tbl[7] = '{255, 1,   1, 32'h0,  1'b0, 255, 255, 1'b0};
        repeat (3) @(negedge clk);
        check("reset_outputs", {ad_start, fifo_wr_en, fifo_rd_en, tx_start, busy, overflow}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) run_session($sformatf("vec%0d", i), tbl[i]);
        for (int i = 0; i < 20; i++) begin
            v.rt   = $urandom_range(1, 12);
            v.div  = $urandom_range(0, 6);
            v.d    = $urandom_range(1, 4);
            v.mask = $urandom & 32'hFFF;
            v.st   = 1'b0;
            v.e_start = v.rt;
            v.e_wr = 0;
            for (int j = 0; j < v.rt; j++) if (!v.mask[j]) v.e_wr++;
            v.e_ovf = v.e_wr < v.rt;
            run_session($sformatf("rand%0d", i), v);
        end
        start_session(4, 3, 2, 32'h2, 1'b0);
        k = 0;
        while (!tx_start && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check("rst_reached_drain", tx_start, 1);
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", {ad_start, fifo_wr_en, fifo_rd_en, tx_start, busy, overflow}, 0);
        repeat (2) @(negedge clk);
        check("rst_held_busy", busy, 0);
        rst_n = 1'b1;
        rd0 = n_rd;
        repeat (20) @(negedge clk);
        check("rst_no_drain", n_rd - rd0, 0);
        check("rst_idle", busy, 0);
        fifo_flush = 1'b1;
        @(negedge clk);
        fifo_flush = 1'b0;
        v = '{2, 3, 2, 32'h0, 1'b0, 2, 2, 1'b0};
        run_session("after_reset", v);
`ifdef AD_CAPTURE_TIMEOUT_EN
        adc_mute = 1'b1;
        start_session(1, 2, 1, 32'h0, 1'b0);
        k = 0;
        while (!timeout && k < 1100) begin
            @(negedge clk);
            k++;
        end
        check("timeout_flag", timeout, 1);
        check("timeout_not_early", k >= 1000, 1);
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("timeout_to_idle", busy, 0);
        adc_mute = 1'b0;
        repeat (5) @(negedge clk);
        v = '{1, 2, 1, 32'h0, 1'b0, 1, 1, 1'b0};
        run_session("post_timeout", v);
        check("timeout_cleared", timeout, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ad_capture_sched.md
AD_CAPTURE_SCHED -- requirements
Module: ad_capture_sched

Interface
REQ-001 Parameter DIV_W, default 16: width of sample_div.
REQ-002 Parameter TIMEOUT_CYC, default 1023: ad_done watchdog limit, in clk cycles.
REQ-003 clk  in  1: single system clock; all logic on its rising edge.
REQ-004 rst_n  in  1: reset, asynchronous, active-low.
REQ-005 set_done  in  1: one-cycle pulse that starts a capture session.
REQ-006 receive_time  in  8: number of samples per session.
REQ-007 sample_div  in  DIV_W: cycles between ad_start pulses.
REQ-008 ad_start  out  1: one-cycle pulse that starts one ADC conversion.
REQ-009 ad_done  in  1: one-cycle pulse when the conversion result is valid.
REQ-010 fifo_full / fifo_empty  in  1 each: FIFO status flags.
REQ-011 fifo_wr_en / fifo_rd_en  out  1 each: FIFO write and read strobes, one cycle each.
REQ-012 tx_start  out  1: one-cycle pulse that launches a UART byte.
REQ-013 tx_done  in  1: one-cycle pulse when the UART byte has completed.
REQ-014 busy  out  1: high in every state except IDLE.
REQ-015 overflow  out  1: sticky flag; a sample was dropped because the FIFO was full.

Function
REQ-016 FSM states SHALL be IDLE, WAIT_TICK, CONV, DRAIN_RD, DRAIN_TX, DRAIN_WAIT.
REQ-017 IDLE SHALL act as follows on set_done:
- Latch receive_time and sample_div.
- Clear cnt and overflow.
- If receive_time==0, stay in IDLE; otherwise go to WAIT_TICK.
REQ-018 WAIT_TICK SHALL count latched sample_div cycles, with sample_div==0 treated as 1.
- At terminal count: pulse ad_start, go to CONV, reload the divider.
REQ-019 CONV, on ad_done:
- Pulse fifo_wr_en in the next cycle if fifo_full==0; otherwise set overflow and do not write.
- Increment cnt in both cases.
- Go to DRAIN_RD if cnt+1==latched count; otherwise go to WAIT_TICK.
REQ-020 DRAIN_RD, if fifo_empty==0:
- Pulse fifo_rd_en and go to DRAIN_TX.
- If fifo_empty==1, go to IDLE.
REQ-021 DRAIN_TX SHALL pulse tx_start exactly one cycle after fifo_rd_en (FIFO read latency is 1 cycle), then go to DRAIN_WAIT.
REQ-022 DRAIN_WAIT SHALL hold until tx_done, then go to DRAIN_RD.
REQ-023 set_done SHALL be ignored in every state except IDLE.
REQ-024 ad_done outside CONV SHALL be ignored: no write, no count.
REQ-025 cnt SHALL be 8 bits; a session of 255 samples SHALL complete without wrap-around.
REQ-026 At most one of ad_start, fifo_wr_en, fifo_rd_en, tx_start SHALL be high in any cycle.

Reset
REQ-027 On rst_n low, asynchronously and in any state including mid-session:
- State goes to IDLE.
- All outputs, cnt, latched values and the divider go to 0.
REQ-028 Samples already in the FIFO SHALL NOT be drained after reset; the FIFO is owned externally.

Configuration
REQ-029 With AD_CAPTURE_TIMEOUT_EN defined, a watchdog SHALL count cycles in CONV.
- If it reaches TIMEOUT_CYC without ad_done: set output timeout (1 bit, sticky, cleared on set_done) and go to DRAIN_RD.
REQ-030 Without AD_CAPTURE_TIMEOUT_EN:
- No watchdog logic and no timeout port.
- CONV waits indefinitely.

Structure
REQ-031 The FSM state enum, the state width and the default DIV_W SHALL live in the shared package ad_uart_pkg.
REQ-032 The divider SHALL be the sub-module sample_tick_gen: load, enable and terminal-count pulse.

Verification
REQ-033 Normal session: set_done with receive_time=4, sample_div=10, ad_done 3 cycles after each ad_start, FIFO never full.
- Expect 4 ad_start pulses spaced 10+ cycles apart.
- Expect 4 fifo_wr_en, then 4 rd_en/tx_start pairs, then IDLE, busy=0.
REQ-034 Zero count: receive_time=0 -> no ad_start, busy stays 0.
REQ-035 Full FIFO: fifo_full=1 during sample 2 of 3 -> 2 writes, overflow=1 until the next set_done.
REQ-036 Reset mid-session: rst_n low during DRAIN_WAIT -> all outputs 0 immediately; after release, set_done starts a fresh session.
REQ-037 Timeout (with AD_CAPTURE_TIMEOUT_EN): no ad_done for 1023 cycles -> timeout=1, state goes to DRAIN_RD.
REQ-038 Stray inputs: set_done in CONV and ad_done in WAIT_TICK -> both ignored; cnt and state unchanged.
